// File: rtl/ipv4_addr_rewriter.sv
// ipv4_addr_rewriter: in-line 64-bit AXI-Stream stage that overwrites the IPv4
// source and/or destination address of Ethernet/IPv4 packets and patches the
// header checksum incrementally in the same pass. Anything else passes
// through unchanged.
module ipv4_addr_rewriter #(
  parameter  int DATA_WIDTH = 64,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  cfg_src_en,
  input  logic                  cfg_dst_en,
  input  logic [31:0]           cfg_src_addr,
  input  logic [31:0]           cfg_dst_addr,
  output logic [31:0]           rewrite_cnt
);

  // Fold a 20-bit one's-complement accumulator into 16 bits (carry folded twice).
  function automatic logic [15:0] csum_fold(input logic [19:0] acc);
    logic [16:0] s1;
    s1 = {1'b0, acc[15:0]} + {13'h0, acc[19:16]};
    return s1[15:0] + {15'h0, s1[16]};
  endfunction

  // Zero-extend a 16-bit checksum term into the accumulator width.
  function automatic logic [19:0] ext20(input logic [15:0] v);
    return {4'h0, v};
  endfunction

  // Output buffer
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d;
  logic [KEEP_WIDTH-1:0] buf_keep_q, buf_keep_d;
  logic                  buf_last_q, buf_last_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  hold_q, hold_d;

  // Packet parse state
  logic [2:0]  wc_q, wc_d;
  logic        elig_q, elig_d;
  logic        cfg_src_en_q, cfg_src_en_d;
  logic        cfg_dst_en_q, cfg_dst_en_d;
  logic [31:0] cfg_src_addr_q, cfg_src_addr_d;
  logic [31:0] cfg_dst_addr_q, cfg_dst_addr_d;
  logic [19:0] csum_acc_q, csum_acc_d;
  logic [31:0] rewrite_cnt_q, rewrite_cnt_d;

  // Combinational helpers
  logic                  accept_s;
  logic                  hold_active_s;
  logic                  hold_set_s;
  logic [DATA_WIDTH-1:0] word_mod_s;
  logic [19:0]           src_part_s;
  logic [19:0]           dst_part_s;
  logic [19:0]           csum_w3_s;
  logic [19:0]           csum_sum_s;
  logic [15:0]           csum_new_s;

  assign hold_active_s = hold_q && buf_valid_q;
  assign accept_s      = s_axis_tvalid && s_axis_tready;
  assign m_axis_tkeep  = buf_keep_q;
  assign m_axis_tlast  = buf_last_q;
  assign rewrite_cnt   = rewrite_cnt_q;

  // Handshake and output data: while word 3 waits for word 4 the stage acts as a wire.
  always_comb begin
    if (hold_active_s) begin
      m_axis_tvalid = s_axis_tvalid;
      s_axis_tready = m_axis_tready;
      m_axis_tdata  = {csum_new_s, buf_data_q[47:0]};
    end else begin
      m_axis_tvalid = buf_valid_q;
      s_axis_tready = !buf_valid_q || m_axis_tready;
      m_axis_tdata  = buf_data_q;
    end
  end

  // Partial checksum sum over the word-3 fields plus the new dst_lo, taken as word 3 is accepted.
  always_comb begin
    if (cfg_src_en_q) begin
      src_part_s = ext20(~s_axis_tdata[47:32]) + ext20(~s_axis_tdata[31:16])
                 + ext20(cfg_src_addr_q[31:16]) + ext20(cfg_src_addr_q[15:0]);
    end else begin
      src_part_s = 20'h0;
    end
    if (cfg_dst_en_q) begin
      dst_part_s = ext20(~s_axis_tdata[15:0]) + ext20(cfg_dst_addr_q[31:16])
                 + ext20(cfg_dst_addr_q[15:0]);
    end else begin
      dst_part_s = 20'h0;
    end
    csum_w3_s = ext20(~s_axis_tdata[63:48]) + src_part_s + dst_part_s;
  end

  // Final checksum during the hold: add the old dst_lo arriving on the input, fold and invert.
  always_comb begin
    if (cfg_dst_en_q) begin
      csum_sum_s = csum_acc_q + ext20(~s_axis_tdata[63:48]);
    end else begin
      csum_sum_s = csum_acc_q;
    end
    csum_new_s = ~csum_fold(csum_sum_s);
  end

  // Word tracking, eligibility, config capture and field substitution for the accepted word.
  always_comb begin
    wc_d           = wc_q;
    elig_d         = elig_q;
    cfg_src_en_d   = cfg_src_en_q;
    cfg_dst_en_d   = cfg_dst_en_q;
    cfg_src_addr_d = cfg_src_addr_q;
    cfg_dst_addr_d = cfg_dst_addr_q;
    csum_acc_d     = csum_acc_q;
    rewrite_cnt_d  = rewrite_cnt_q;
    hold_set_s     = 1'b0;
    word_mod_s     = s_axis_tdata;
    if (accept_s) begin
      if (s_axis_tlast) begin
        wc_d = 3'd0;
      end else if (wc_q == 3'd5) begin
        wc_d = 3'd5;
      end else begin
        wc_d = wc_q + 3'd1;
      end
      case (wc_q)
        3'd0: begin
          cfg_src_en_d   = cfg_src_en;
          cfg_dst_en_d   = cfg_dst_en;
          cfg_src_addr_d = cfg_src_addr;
          cfg_dst_addr_d = cfg_dst_addr;
          elig_d         = 1'b0;
        end
        3'd1: begin
          elig_d = (s_axis_tdata[31:16] == 16'h0800) && (cfg_src_en_q || cfg_dst_en_q)
                   && !s_axis_tlast;
        end
        3'd2: begin
          elig_d = elig_q && !s_axis_tlast;
        end
        3'd3: begin
          if (elig_q && !s_axis_tlast) begin
            hold_set_s = 1'b1;
            csum_acc_d = csum_w3_s;
            if (cfg_src_en_q) begin
              word_mod_s[47:16] = cfg_src_addr_q;
            end else begin
              word_mod_s[47:16] = s_axis_tdata[47:16];
            end
            if (cfg_dst_en_q) begin
              word_mod_s[15:0] = cfg_dst_addr_q[31:16];
            end else begin
              word_mod_s[15:0] = s_axis_tdata[15:0];
            end
          end else begin
            elig_d = 1'b0;
          end
        end
        3'd4: begin
          if (elig_q) begin
            rewrite_cnt_d = rewrite_cnt_q + 32'd1;
            if (cfg_dst_en_q) begin
              word_mod_s[63:48] = cfg_dst_addr_q[15:0];
            end else begin
              word_mod_s[63:48] = s_axis_tdata[63:48];
            end
          end else begin
            rewrite_cnt_d = rewrite_cnt_q;
          end
          elig_d = 1'b0;
        end
        default: begin
          elig_d = elig_q;
        end
      endcase
    end else begin
      wc_d = wc_q;
    end
  end

  // Output buffer: load on accept, empty on drain, otherwise hold steady under backpressure.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_keep_d  = buf_keep_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    hold_d      = hold_q;
    if (accept_s) begin
      buf_data_d  = word_mod_s;
      buf_keep_d  = s_axis_tkeep;
      buf_last_d  = s_axis_tlast;
      buf_valid_d = 1'b1;
      hold_d      = hold_set_s;
    end else if (m_axis_tvalid && m_axis_tready) begin
      buf_valid_d = 1'b0;
      hold_d      = 1'b0;
    end else begin
      buf_valid_d = buf_valid_q;
    end
  end

  // State registers with asynchronous reset; a reset drops any partial packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q     <= {DATA_WIDTH{1'b0}};
      buf_keep_q     <= {KEEP_WIDTH{1'b0}};
      buf_last_q     <= 1'b0;
      buf_valid_q    <= 1'b0;
      hold_q         <= 1'b0;
      wc_q           <= 3'd0;
      elig_q         <= 1'b0;
      cfg_src_en_q   <= 1'b0;
      cfg_dst_en_q   <= 1'b0;
      cfg_src_addr_q <= 32'h0;
      cfg_dst_addr_q <= 32'h0;
      csum_acc_q     <= 20'h0;
      rewrite_cnt_q  <= 32'h0;
    end else begin
      buf_data_q     <= buf_data_d;
      buf_keep_q     <= buf_keep_d;
      buf_last_q     <= buf_last_d;
      buf_valid_q    <= buf_valid_d;
      hold_q         <= hold_d;
      wc_q           <= wc_d;
      elig_q         <= elig_d;
      cfg_src_en_q   <= cfg_src_en_d;
      cfg_dst_en_q   <= cfg_dst_en_d;
      cfg_src_addr_q <= cfg_src_addr_d;
      cfg_dst_addr_q <= cfg_dst_addr_d;
      csum_acc_q     <= csum_acc_d;
      rewrite_cnt_q  <= rewrite_cnt_d;
    end
  end

endmodule

// File: doc/ipv4_addr_rewriter.md
Name: ipv4_addr_rewriter

Overview:
- In-line AXI-Stream stage on the 64-bit packet path, counterpart to the ipfilter header parser.
- Parses Ethernet/IPv4 packets and writes the IPv4 source and/or destination address fields with configured values.
- Updates the IPv4 header checksum incrementally (RFC 1624) in the same pass.
- Non-IPv4 and short packets pass through bit-exact. Placed on the ipfilter TX side; a NAT-style address writer.

Parameters:
- DATA_WIDTH, 64, stream width. Only 64 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width (localparam).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- s_axis_tdata  in  64  input data, network byte order; byte k of a word is at bits [63-8k -: 8].
- s_axis_tkeep  in  8  input byte enables, passed through unmodified.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  64  output data.
- m_axis_tkeep  out  8  output byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- cfg_src_en  in  1  rewrite the source address.
- cfg_dst_en  in  1  rewrite the destination address.
- cfg_src_addr  in  32  new source address.
- cfg_dst_addr  in  32  new destination address.
- rewrite_cnt  out  32  count of packets rewritten; wraps at 2^32.

Behaviour:
- Reset: m_axis_tvalid=0, all output registers 0, rewrite_cnt=0, word counter 0, s_axis_tready=1 after reset release.
- Datapath: one-entry output register (buf). Each input word is accepted into buf on s_tvalid&&s_tready.
  - Minimum latency 1 cycle. Full throughput except for the word-3 hold below.
- Word counter wc (3 bits) counts accepted input words. It saturates at 5 and returns to 0 after the tlast word.
- Config capture: cfg_* is sampled when word 0 is accepted and held for the whole packet. Mid-packet cfg changes take effect on the next packet.
- Eligibility:
  - wc==1: eligible = (tdata[31:16]==16'h0800) && (cfg_src_en||cfg_dst_en).
  - A word 1, 2 or 3 carrying tlast clears eligible for that packet; the packet passes unmodified.
- Field positions in the 64-bit words:
  - Word 3: checksum [63:48], src [47:16], dst_hi [15:0].
  - Word 4: dst_lo [63:48].
- Applied on accept into buf:
  - Word 3: src replaced if cfg_src_en; dst_hi replaced if cfg_dst_en.
  - Word 4: dst_lo replaced if cfg_dst_en.
- Word-3 hold:
  - While buf holds word 3 of an eligible packet, m_axis_tvalid = s_axis_tvalid, and s_axis_tready = m_axis_tready.
  - The emitted checksum is computed combinationally from the old dst_lo at s_axis_tdata[63:48].
  - Word 3 leaves and word 4 enters buf in the same cycle.
  - This hold is the only combinational s->m path. AXIS valid stability holds because upstream must keep tvalid asserted.
- Otherwise:
  - m_axis_tvalid = buf valid.
  - s_axis_tready = !buf valid || m_axis_tready (pass-through when not eligible).
- Checksum:
  - HC' = ~(~HC +' ~old fields +' new fields) over the replaced 16-bit halves only, where +' is one's-complement add.
  - Accumulate in a 20-bit adder, then fold the carry twice into 16 bits.
  - If no rewrite is enabled, the checksum is unchanged.
- rewrite_cnt increments by 1 when word 4 of an eligible packet is accepted.
- Backpressure: buf holds its data while m_axis_tvalid && !m_axis_tready. tdata/tkeep/tlast remain stable.
- Back-to-back packets: wc returns to 0 after the tlast word is accepted. The next word is word 0 with no bubble.
- Reset mid-packet: buf is cleared, so the partial packet is dropped downstream. wc=0 and the next accepted word is treated as word 0.

Test Plan:
- Header "4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7", ethertype 0800, cfg_src_en=1, cfg_src_addr=0a000001, cfg_dst_en=0 -> out word3 = 6f0a_0a00_0001_c0a8; other words bit-exact; rewrite_cnt=1.
- Same header with both enables, src=c0a80001, dst=c0a800c7 (identity rewrite) -> checksum stays b861; output is bit-exact to input.
- Ethertype 86dd (IPv6), both enables set -> all words bit-exact; rewrite_cnt stays 0.
- 4-word IPv4 packet with tlast on word 3 -> passes unmodified; no hold stall; next packet is parsed from word 0.
- Random m_axis_tready (50%) and gapped s_axis_tvalid over 100 back-to-back rewritten packets -> no data loss or duplication; checksums match a reference model.
- rst asserted after word 2 of a packet -> m_axis_tvalid drops immediately; the following full packet is rewritten correctly.
